// File: rtl/demux1x2_stream_pkg.sv
// demux_pkg: shared defaults and route-select encoding for demux1x2_stream.
//   DATA_W_DEF : default word width
//   DEPTH_DEF  : default entries per output queue (power of 2, >= 2)
//   SEL_A/SEL_B: value of Es that routes a word to output A / output B
package demux_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic logic sel_is_b(input logic es);
    return es == SEL_B;
  endfunction

endpackage

// File: rtl/demux1x2_stream_if.sv
// demux1x2_stream_if: stream bundle for the 1-to-2 demux.
//   Y, Es, in_valid -> input word, route select, input valid
//   in_ready        <- demux can accept the input word
//   A, a_valid      <- output A head word and valid; a_ready -> consumer A takes it
//   B, b_valid      <- output B head word and valid; b_ready -> consumer B takes it
// master: producer/consumer side.  slave: the demux itself.
interface demux1x2_stream_if
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] Y;
  logic              Es;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] A;
  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] B;
  logic              b_valid;
  logic              b_ready;

  modport master (
    output Y, Es, in_valid, a_ready, b_ready,
    input  in_ready, A, a_valid, B, b_valid
  );

  modport slave (
    input  Y, Es, in_valid, a_ready, b_ready,
    output in_ready, A, a_valid, B, b_valid
  );
endinterface

// File: rtl/demux1x2_stream_fifo_sync.sv
// fifo_sync: single-clock FIFO used as one output queue of the demux.
//   clk, rst_n : clock, asynchronous active-low reset (empties the queue)
//   push_i/din_i : write din_i (ignored when full)
//   pop_i      : drop the head word (ignored when empty)
//   full_o/empty_o : registered-state occupancy flags
//   head_o     : head word, all zeros while empty
module fifo_sync
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  // Storage is never cleared; gating the head on empty keeps stale words hidden.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers are log2(DEPTH) wide so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/demux1x2_stream.sv
// demux1x2_stream: routes an input stream to one of two queued outputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : demux1x2_stream_if slave modport (input stream Y/Es,
//                output streams A and B with valid/ready each)
// Each output has its own fifo_sync, so a stalled consumer only blocks
// words routed to it.
module demux1x2_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux1x2_stream_if.slave      bus
);
  logic full_a, full_b;
  logic empty_a, empty_b;
  logic sel_b;
  logic accept;
  logic push_a, push_b;
  logic pop_a, pop_b;

  assign sel_b = sel_is_b(bus.Es);

  // Ready depends only on Es and registered full flags, never on a_ready/b_ready,
  // so a same-cycle pop on a full queue does not open the input.
  assign bus.in_ready = sel_b ? ~full_b : ~full_a;
  assign accept       = bus.in_valid & bus.in_ready;
  assign push_a       = accept & ~sel_b;
  assign push_b       = accept &  sel_b;
  assign pop_a        = bus.a_ready & ~empty_a;
  assign pop_b        = bus.b_ready & ~empty_b;

  assign bus.a_valid = ~empty_a;
  assign bus.b_valid = ~empty_b;

  fifo_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_a),
    .din_i   (bus.Y),
    .pop_i   (pop_a),
    .full_o  (full_a),
    .empty_o (empty_a),
    .head_o  (bus.A)
  );

  fifo_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_b),
    .din_i   (bus.Y),
    .pop_i   (pop_b),
    .full_o  (full_b),
    .empty_o (empty_b),
    .head_o  (bus.B)
  );
endmodule

// File: tb/tb_demux1x2_stream.sv
// Testbench for demux1x2_stream (DATA_W=8, DEPTH=2).
module tb_demux1x2_stream;
  logic clk;
  logic rst_n;

  demux1x2_stream_if #(.DATA_W(8)) bus ();

  demux1x2_stream #(.DATA_W(8), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic       es;
    logic [7:0] y;
    logic       ar;
    logic       br;
    logic       e_ir;
    logic       e_av;
    logic [7:0] e_a;
    logic       e_bv;
    logic [7:0] e_b;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic vec_t mk(input logic iv, input logic es, input logic [7:0] y,
                              input logic ar, input logic br, input logic e_ir,
                              input logic e_av, input logic [7:0] e_a,
                              input logic e_bv, input logic [7:0] e_b);
    vec_t v;
    v.iv = iv; v.es = es; v.y = y; v.ar = ar; v.br = br;
    v.e_ir = e_ir; v.e_av = e_av; v.e_a = e_a; v.e_bv = e_bv; v.e_b = e_b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic iv, input logic es, input logic [7:0] y,
                       input logic ar, input logic br);
    bus.in_valid = iv;
    bus.Es       = es;
    bus.Y        = y;
    bus.a_ready  = ar;
    bus.b_ready  = br;
  endtask

  initial begin
    // Expected outputs are those seen before the edge that applies the vector.
    //               iv    es    y      ar    br    ir    av    A      bv    B
    vecs[0]  = mk(1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    vecs[1]  = mk(1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00);
    vecs[2]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h22);
    vecs[3]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    vecs[4]  = mk(1'b1, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    vecs[5]  = mk(1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b0, 8'h00);
    vecs[6]  = mk(1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 8'h00);
    vecs[7]  = mk(1'b1, 1'b1, 8'h5B, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0, 8'h00);
    vecs[8]  = mk(1'b1, 1'b0, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1, 8'h5B);
    vecs[9]  = mk(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b1, 8'h5B);
    vecs[10] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 8'h5B);
    vecs[11] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b1, 8'h5B);
    vecs[12] = mk(1'b1, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5B);
    vecs[13] = mk(1'b1, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5B);
    vecs[14] = mk(1'b1, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hB1);
    vecs[15] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hB2);
    vecs[16] = mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    vecs[17] = mk(1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

    // Reset held with a valid word presented.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready(Es=0)", {7'd0, bus.in_ready}, 8'h01);
    chk("rst a_valid", {7'd0, bus.a_valid}, 8'h00);
    chk("rst b_valid", {7'd0, bus.b_valid}, 8'h00);
    chk("rst A", bus.A, 8'h00);
    chk("rst B", bus.B, 8'h00);
    bus.Es = 1'b1;
    #1;
    chk("rst in_ready(Es=1)", {7'd0, bus.in_ready}, 8'h01);

    // Release with no valid input: nothing held over from reset.
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst a_valid", {7'd0, bus.a_valid}, 8'h00);
    chk("post-rst b_valid", {7'd0, bus.b_valid}, 8'h00);

    // Word waiting across release is taken at the first edge with rst_n=1.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #1;
    chk("first xfer a_valid", {7'd0, bus.a_valid}, 8'h01);
    chk("first xfer A", bus.A, 8'h3C);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("drain a_valid", {7'd0, bus.a_valid}, 8'h00);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].es, vecs[i].y, vecs[i].ar, vecs[i].br);
      #1;
      chk($sformatf("v%0d in_ready", i), {7'd0, bus.in_ready}, {7'd0, vecs[i].e_ir});
      chk($sformatf("v%0d a_valid", i),  {7'd0, bus.a_valid},  {7'd0, vecs[i].e_av});
      chk($sformatf("v%0d A", i),        bus.A,                vecs[i].e_a);
      chk($sformatf("v%0d b_valid", i),  {7'd0, bus.b_valid},  {7'd0, vecs[i].e_bv});
      chk($sformatf("v%0d B", i),        bus.B,                vecs[i].e_b);
      @(posedge clk); #1;
    end

    // Mid-operation reset with both queues occupied.
    drive(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 8'h88, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #1;
    chk("pre-mid a_valid", {7'd0, bus.a_valid}, 8'h01);
    chk("pre-mid A", bus.A, 8'h77);
    chk("pre-mid b_valid", {7'd0, bus.b_valid}, 8'h01);
    chk("pre-mid B", bus.B, 8'h88);
    rst_n = 1'b0;
    #1;
    chk("mid-rst a_valid", {7'd0, bus.a_valid}, 8'h00);
    chk("mid-rst b_valid", {7'd0, bus.b_valid}, 8'h00);
    chk("mid-rst A", bus.A, 8'h00);
    chk("mid-rst B", bus.B, 8'h00);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after mid-rst a_valid", {7'd0, bus.a_valid}, 8'h00);
    chk("after mid-rst b_valid", {7'd0, bus.b_valid}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
